// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add controller.
//   state_e       : FSM state encoding (IDLE -> RUN -> DONE -> IDLE)
//   DEFAULT_WIDTH : default operand/sum width
//   DEFAULT_CNT_W : default bit-counter width, clog2(DEFAULT_WIDTH)
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_bit_counter.sv
// Bit-position counter for the serial adder.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : increment enable
//   tc_c       : terminal count, high while cnt == TC_VAL
module serial_bit_counter #(
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned TC_VAL = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == CNT_W'(TC_VAL));

endmodule : serial_bit_counter

// File: rtl/serial_add_sequencer.sv
// Bit-serial add controller driving an external single-bit full adder, LSB first.
//   clk, rst_n        : clock, async active-low reset
//   start             : add request, sampled only in IDLE
//   a, b, cin         : operands and initial carry, latched on accepted start
//   fa_x, fa_y, fa_cin: bit pair and running carry to the adder (0 outside RUN)
//   fa_s, fa_cout     : sum and carry back from the adder
//   busy              : high while in RUN
//   done              : one-cycle pulse when sum/cout are updated
//   sum, cout         : assembled result, held until the end of the next add
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             last_bit_c;
    logic             run_c;

    serial_bit_counter #(
        .CNT_W  (CNT_W),
        .TC_VAL (WIDTH - 1)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc_c  (last_bit_c)
    );

    // Adder drive is gated by state so nothing leaks out in IDLE/DONE.
    assign run_c  = (state_q == ST_RUN);
    assign fa_x   = run_c & a_sh_q[0];
    assign fa_y   = run_c & b_sh_q[0];
    assign fa_cin = run_c & carry_q;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_clr  = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                cnt_en   = 1'b1;
                if (last_bit_c) begin
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: serial_add_sequencer plus a behavioural full adder.
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         fa_x, fa_y, fa_cin, fa_s, fa_cout;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_checks;
    int n_err;

    serial_add_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .fa_x    (fa_x),
        .fa_y    (fa_y),
        .fa_cin  (fa_cin),
        .fa_s    (fa_s),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    // The single-bit full adder the controller talks to.
    assign fa_s    = fa_x ^ fa_y ^ fa_cin;
    assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {22'd0, sum, cout, done, busy, fa_x, fa_y, fa_cin};
    endfunction

    // One complete add from IDLE; start is a single-cycle pulse.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tc, input logic [W-1:0] es, input logic ec,
                           input string nm);
        int  edges;
        int  busy_n;
        int  leak;
        bit  got;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        edges = 0; busy_n = 0; leak = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (!busy && (fa_x || fa_y || fa_cin)) leak++;
            if (done) got = 1'b1;
        end
        check({nm, "_done_seen"}, 32'(got), 32'd1);
        check({nm, "_latency"}, 32'(edges), 32'(W + 1));
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'(W));
        check({nm, "_fa_leak"}, 32'(leak), 32'd0);
        check({nm, "_sum"}, 32'(sum), 32'(es));
        check({nm, "_cout"}, 32'(cout), 32'(ec));
        @(negedge clk);
        check({nm, "_done_pulse"}, 32'(done), 32'd0);
        check({nm, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        int leak;
        int sviol;
        int last_done;
        int periods_bad;
        logic [W-1:0] prev_sum;
        logic [W-1:0] exp_s;

        n_checks = 0;
        n_err    = 0;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        check("reset_outputs", out_vec(), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].esum, vecs[i].ecout,
                    $sformatf("vec%0d", i));
        end

        // Start during RUN with new operands must be ignored.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);           // RUN cycle 1
        start = 1'b0;
        @(negedge clk);           // RUN cycle 2
        @(negedge clk);           // RUN cycle 3
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("ign_start_dones", 32'(dn), 32'd1);
        check("ign_start_sum", 32'(sum), 32'h10);
        check("ign_start_cout", 32'(cout), 32'd0);

        // Reset in RUN cycle 4 aborts at once.
        @(negedge clk);
        a = 8'hFF; b = 8'h00; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_fa_x", 32'(fa_x), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", out_vec(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("post_reset_no_done", 32'(dn), 32'd0);
        run_add(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, "after_reset");

        // Start held high: back-to-back adds every W+2 cycles; operands change each result.
        @(negedge clk);
        a = 8'h01; b = 8'h10; cin = 1'b0; start = 1'b1;
        dn = 0; leak = 0; sviol = 0; last_done = -1; periods_bad = 0;
        prev_sum = sum;
        exp_s = 8'h11;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (!busy && (fa_x || fa_y || fa_cin)) leak++;
            if (sum !== prev_sum && !done) sviol++;
            prev_sum = sum;
            if (done) begin
                check($sformatf("held_start_sum%0d", dn), 32'(sum), 32'(exp_s));
                if (last_done >= 0 && (cyc - last_done) != int'(W + 2)) periods_bad++;
                last_done = cyc;
                dn++;
                a = a + 8'h01;
                exp_s = a + b;
            end
        end
        start = 1'b0;
        check("held_start_dones", 32'(dn), 32'd4);
        check("held_start_period", 32'(periods_bad), 32'd0);
        check("held_start_sum_stable", 32'(sviol), 32'd0);
        check("held_start_fa_leak", 32'(leak), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_serial_add_sequencer
